// File: rtl/lab61soc_accumulate_ctrl_if.sv
// rtl/lab61soc_accumulate_ctrl_if.sv - Avalon-MM slave bundle for the accumulate controller
// Purpose: groups the 4-word register bus so the controller and its host see one port.
// Signals:
//   address    [1:0]  word address (0 ACC, 1 EDGE, 2 MASK, 3 STATUS)
//   chipselect        slave select
//   write_n           write strobe, active-low
//   writedata  [31:0] write data
//   readdata   [31:0] read data, registered inside the slave (latency 1)
`timescale 1ns/1ps
interface lab61soc_accumulate_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab61soc_accumulate_ctrl.sv
// rtl/lab61soc_accumulate_ctrl.sv - debounced key press accumulator with Avalon-MM registers and IRQ
// Purpose: debounces the active-low accumulate key and adds the switch value into an accumulator on
// every clean press; exposes accumulator, edge capture, IRQ mask and press count to the CPU.
// Ports:
//   clk, reset_n  clock; asynchronous active-low reset clearing every flop
//   key_n         raw button, 0 = pressed, asynchronous to clk
//   sw            raw switches, asynchronous to clk
//   avs           Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   irq           level interrupt = edge & mask, registered
//   acc_out       live accumulator value for the hex display
`timescale 1ns/1ps
module lab61soc_accumulate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       key_n,
  input  logic [DATA_W-1:0]          sw,
  lab61soc_accumulate_ctrl_if.slave  avs,
  output logic                       irq,
  output logic [DATA_W-1:0]          acc_out
);

  typedef enum logic [1:0] {
    IDLE_UP = 2'd0,
    WAIT_DN = 2'd1,
    PRESSED = 2'd2,
    WAIT_UP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The key is synchronised already inverted so that the cleared reset
  // value of the synchroniser means "released".
  logic              press_meta_q, press_meta_d;
  logic              pressed_s_q, pressed_s_d;
  logic [DATA_W-1:0] sw_meta_q, sw_meta_d;
  logic [DATA_W-1:0] sw_s_q, sw_s_d;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_pulse;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [7:0]        count_q, count_d;
  logic              edge_cap_q, edge_cap_d;
  logic              mask_q, mask_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr_en, wr_acc, wr_edge, wr_mask;
  logic              debounced_level;
  logic              unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_meta_q <= 1'b0;
      pressed_s_q  <= 1'b0;
      sw_meta_q    <= '0;
      sw_s_q       <= '0;
      state_q      <= IDLE_UP;
      cnt_q        <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      edge_cap_q   <= 1'b0;
      mask_q       <= 1'b0;
      irq_q        <= 1'b0;
      readdata_q   <= '0;
    end else begin
      press_meta_q <= press_meta_d;
      pressed_s_q  <= pressed_s_d;
      sw_meta_q    <= sw_meta_d;
      sw_s_q       <= sw_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      edge_cap_q   <= edge_cap_d;
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

  always_comb begin
    press_meta_d = ~key_n;
    pressed_s_d  = press_meta_q;
    sw_meta_d    = sw;
    sw_s_d       = sw_meta_q;
  end

  // Debounce FSM: a level change must hold for DEBOUNCE_CYCLES consecutive
  // cycles; the only pulse is on the WAIT_DN -> PRESSED transition, so a
  // bounce on release (WAIT_UP -> PRESSED) never counts twice.
  always_comb begin
    state_d     = state_q;
    press_pulse = 1'b0;
    case (state_q)
      IDLE_UP: begin
        if (pressed_s_q) state_d = WAIT_DN;
      end
      WAIT_DN: begin
        if (!pressed_s_q) begin
          state_d = IDLE_UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          press_pulse = 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed_s_q) state_d = WAIT_UP;
      end
      WAIT_UP: begin
        if (pressed_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_UP;
        end
      end
      default: state_d = IDLE_UP;
    endcase

    // Counter restarts on every state entry and only runs in the wait states.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == WAIT_DN || state_q == WAIT_UP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    wr_en   = avs.chipselect & ~avs.write_n;
    wr_acc  = wr_en && (avs.address == 2'd0);
    wr_edge = wr_en && (avs.address == 2'd1);
    wr_mask = wr_en && (avs.address == 2'd2);

    // A clear that lands on a press adds onto the cleared value.
    acc_d = acc_q;
    if (press_pulse) begin
      acc_d = wr_acc ? sw_s_q : acc_q + sw_s_q;
    end else if (wr_acc) begin
      acc_d = '0;
    end

    count_d = press_pulse ? count_q + 8'd1 : count_q;

    // A new press beats a simultaneous write-1-to-clear.
    edge_cap_d = edge_cap_q;
    if (press_pulse) begin
      edge_cap_d = 1'b1;
    end else if (wr_edge && avs.writedata[0]) begin
      edge_cap_d = 1'b0;
    end

    mask_d = wr_mask ? avs.writedata[0] : mask_q;
    irq_d  = edge_cap_q & mask_q;

    debounced_level = (state_q == PRESSED) || (state_q == WAIT_UP);

    readdata_d = '0;
    case (avs.address)
      2'd0: readdata_d[DATA_W-1:0] = acc_q;
      2'd1: readdata_d[0]          = edge_cap_q;
      2'd2: readdata_d[0]          = mask_q;
      default: begin
        readdata_d[17:16] = state_q;
        readdata_d[15:8]  = count_q;
        readdata_d[0]     = debounced_level;
      end
    endcase
  end

  assign unused_wdata = ^avs.writedata[31:1];

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;
  assign acc_out      = acc_q;

endmodule

// File: tb/tb_lab61soc_accumulate_ctrl.sv
// tb/tb_lab61soc_accumulate_ctrl.sv - scoreboard bench for lab61soc_accumulate_ctrl
`timescale 1ns/1ps
module tb_lab61soc_accumulate_ctrl;

  localparam int DEB    = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              key_n = 1'b1;
  logic [DATA_W-1:0] sw = '0;
  logic              irq;
  logic [DATA_W-1:0] acc_out;

  lab61soc_accumulate_ctrl_if bus();

  lab61soc_accumulate_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(20),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n(key_n),
    .sw(sw),
    .avs(bus),
    .irq(irq),
    .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        irq;
    logic [15:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: what the register file should hold after each event.
  logic [15:0] m_acc   = '0;
  logic [7:0]  m_count = '0;
  logic        m_edge  = 1'b0;
  logic        m_mask  = 1'b0;

  function automatic logic [31:0] model_rd(input logic [1:0] a, input logic [1:0] st, input logic lvl);
    case (a)
      2'd0:    return {16'h0, m_acc};
      2'd1:    return {31'b0, m_edge};
      2'd2:    return {31'b0, m_mask};
      default: return {14'b0, st, m_count, 7'b0, lvl};
    endcase
  endfunction

  task automatic model_reset();
    m_acc = '0; m_count = '0; m_edge = 1'b0; m_mask = 1'b0;
  endtask

  task automatic apply_press(input logic [15:0] v);
    m_acc   = m_acc + v;
    m_count = m_count + 8'd1;
    m_edge  = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issue a one-cycle read; the expected response is queued for the monitor.
  task automatic rd(input logic [1:0] a, input logic [1:0] st, input logic lvl);
    exp_t e;
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    e.addr = a;
    e.rd   = model_rd(a, st, lvl);
    e.irq  = m_edge & m_mask;
    e.acc  = m_acc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic rd_idle_all();
    for (int a = 0; a < 4; a++) rd(2'(a), 2'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    case (a)
      2'd0: m_acc = '0;
      2'd1: if (d[0]) m_edge = 1'b0;
      2'd2: m_mask = d[0];
      default: ;
    endcase
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic press(input logic [15:0] v, input int hold, input bit check_lat);
    sw = v;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    if (check_lat) begin
      repeat (DEB + 2) @(negedge clk);
      chk("latency_before", {16'h0, acc_out}, {16'h0, m_acc});
      @(negedge clk);
      apply_press(v);
      chk("latency_after", {16'h0, acc_out}, {16'h0, m_acc});
      repeat (hold - DEB - 3) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
      apply_press(v);
    end
    rd(2'd3, 2'd2, 1'b1);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Presents a register write exactly in the press_pulse cycle.
  task automatic press_collide(input logic [15:0] v, input logic [1:0] a, input logic [31:0] d);
    sw = v;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    wr(a, d);
    apply_press(v);
    repeat (6) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    key_n = 1'b0;
    repeat (len) @(negedge clk);
    key_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: a read issued in the previous cycle has its data valid now.
  logic rd_issue_q = 1'b0;
  exp_t mon_e;
  always @(posedge clk) rd_issue_q <= bus.chipselect & bus.write_n;

  always @(negedge clk) begin
    if (rd_issue_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got rd=%h exp=<queued entry>", bus.readdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.readdata !== mon_e.rd || irq !== mon_e.irq || acc_out !== mon_e.acc) begin
          failures++;
          $display("FAIL rd_addr%0d got rd=%h irq=%b acc=%h exp rd=%h irq=%b acc=%h",
                   mon_e.addr, bus.readdata, irq, acc_out, mon_e.rd, mon_e.irq, mon_e.acc);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    int          act;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();

    // Reset values.
    rd_idle_all();

    // Clean presses, first one with exact latency.
    press(16'h0005, 20, 1'b1);
    rd_idle_all();
    press(16'h0003, 12, 1'b0);
    rd_idle_all();

    // Glitches shorter than the debounce window.
    sw = 16'h1234;
    glitch(2);
    glitch(3);
    rd_idle_all();

    // Release bounce: WAIT_UP must hold 4 stable-high cycles before IDLE_UP.
    sw = 16'h0010;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    apply_press(16'h0010);
    key_n = 1'b1; @(negedge clk);
    key_n = 1'b0; @(negedge clk);
    key_n = 1'b1; @(negedge clk);
    key_n = 1'b0; @(negedge clk);
    key_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(2'd3, 2'd3, 1'b1);
    rd(2'd3, 2'd3, 1'b1);
    rd(2'd3, 2'd0, 1'b0);

    // Accumulator wrap and IRQ.
    wr(2'd0, 32'h0);
    press(16'hFFFF, 10, 1'b0);
    press(16'h0002, 10, 1'b0);
    rd(2'd0, 2'd0, 1'b0);
    wr(2'd2, 32'h1);
    rd_idle_all();
    press_collide(16'h0004, 2'd1, 32'h1);
    rd_idle_all();
    wr(2'd1, 32'h0);
    rd(2'd1, 2'd0, 1'b0);
    wr(2'd1, 32'h1);
    rd_idle_all();

    // Clear collision and ignored STATUS write.
    press_collide(16'h0007, 2'd0, 32'hDEAD_BEEF);
    rd_idle_all();
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 2'd0, 1'b0);

    // Randomized traffic; enough presses to wrap the 8-bit count.
    for (int i = 0; i < 260; i++) begin
      act = int'($urandom_range(0, 9));
      v   = 16'($urandom);
      if (act < 2) begin
        sw = v;
        glitch(int'($urandom_range(1, 3)));
      end else begin
        press(v, int'($urandom_range(8, 16)), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) wr(2'd0, $urandom);
      if ($urandom_range(0, 3) == 0) wr(2'd1, $urandom);
      if ($urandom_range(0, 3) == 0) wr(2'd2, $urandom);
      if (i % 8 == 0) rd_idle_all();
      else rd(2'($urandom_range(0, 3)), 2'd0, 1'b0);
    end

    // Reset while in WAIT_DN with the key released during reset.
    sw = 16'h0009;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    key_n   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rd_idle_all();

    // Reset while in WAIT_DN with the key held: a full debounce is needed again.
    key_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (DEB + 2) @(negedge clk);
    chk("rst_held_before", {16'h0, acc_out}, 32'h0);
    @(negedge clk);
    apply_press(16'h0009);
    chk("rst_held_after", {16'h0, acc_out}, {16'h0, m_acc});
    repeat (4) @(negedge clk);
    rd(2'd3, 2'd2, 1'b1);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_idle_all();

    repeat (4) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
